hazard_ctrl: RTL

Pipeline hazard controller for the five-stage core. It generates the stall and flush controls for the fetch, decode and execute pipeline registers, and the execute-stage operand forwarding selects. It also sequences multi-cycle floating-point operations by holding them in execute for a fixed latency. It sits beside the DEC→EXE register and drives that register's `stall` and `flush` inputs.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_ctrl_fp_seq.sv | 71 +++++++
 rtl/hazard_ctrl.sv | 64 ++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and encodings for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fp_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Memory stage wins over writeback; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic       reg_write_m,
    input logic [4:0] rd_m,
    input logic       reg_write_w,
    input logic [4:0] rd_w,
    input logic [4:0] rs
  );
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fp_seq.sv
// rtl/hazard_ctrl_fp_seq.sv - holds a multi-cycle FP op in execute for FP_LATENCY cycles
module fp_seq
  import hazard_pkg::*;
#(
  parameter int FP_LATENCY = 4,
  parameter int CNT_W      = $clog2(FP_LATENCY)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic floatingE,
  output logic fpStall,
  output logic fp_start,
  output logic fp_done,
  output logic fp_busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FP_LATENCY - 2);

  fp_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fp_busy_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fpStall  = 1'b0;
    fp_start = 1'b0;
    fp_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (floatingE) begin
          fpStall  = 1'b1;
          fp_start = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // floatingE is ignored here: the op being timed is already held in execute
        if (cnt_q != '0) begin
          fpStall = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          fp_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) begin
      fpStall  = 1'b0;
      fp_start = 1'b0;
      fp_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      fp_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fp_busy_q <= (state_d == BUSY);
    end
  end

  assign fp_busy = fp_busy_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush generation and operand forwarding for the five-stage core
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FP_LATENCY = 4,
  parameter int CNT_W      = $clog2(FP_LATENCY)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       isLoadE,
  input  logic       floatingE,
  input  logic       PCSrcE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       fp_start,
  output logic       fp_done,
  output logic       fp_busy
);

  logic lwStall;
  logic fpStall;
  logic branch;

  fp_seq #(
    .FP_LATENCY(FP_LATENCY),
    .CNT_W     (CNT_W)
  ) u_fp_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .floatingE(floatingE),
    .fpStall  (fpStall),
    .fp_start (fp_start),
    .fp_done  (fp_done),
    .fp_busy  (fp_busy)
  );

  assign ForwardAE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
  assign ForwardBE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs2E);

  // Reset quiets every control output; forwarding stays purely combinational.
  assign lwStall = rst_n && isLoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign branch  = rst_n && PCSrcE;

  assign StallF = lwStall || fpStall;
  assign StallD = lwStall || fpStall;
  assign StallE = fpStall;
  assign FlushD = branch && !fpStall;
  assign FlushE = (lwStall || branch) && !fpStall;

endmodule
